led_bar_scheduler: RTL and testbench
====================================

// Module: led_bar_scheduler
// PURPOSE
//  Owns the 8-LED bar on the piano board and shares it between three requesters.
//  Requesters, in priority order: key-press echo, song-playback progress, water-light pattern.
//  Generates the beat square wave that clocks the water-light pattern generator.
//  Registers the winning source onto the LED pins.
//  Sits between the keyboard decoder / playback sequencer and the board LED outputs.
// PARAMETERS
//  BEAT_DIV  12_500_000  clk cycles per beat half-period (beat period = 2*BEAT_DIV)
//  HOLD_CYC  25_000_000  clk cycles a key echo holds the bar after the last key_valid (>=1)
//  CNT_W     25          width of the beat and hold counters (must hold max(BEAT_DIV,HOLD_CYC))
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  func         in   4  mode select; func[1:0]==2'b01 or 2'b10 -> water light enabled
//  key_valid    in   1  one-clk pulse, new key pressed
//  key_code     in   4  key index sampled when key_valid=1
//  play_active  in   1  level, playback sequencer running
//  play_note    in   3  current playback note 0..7
//  wl_pattern   in   8  pattern from the water-light generator
//  beat         out  1  beat square wave to the water-light generator
//  led          out  8  LED bar drive, registered
//  src          out  2  current owner: 0 IDLE, 1 WATER, 2 PLAY, 3 KEY
// BEHAVIOUR
//  Reset (async, rst_n=0): led=0, beat=0, src=0, state=IDLE, both counters=0, key latch=0.
//  Reset mid-operation: the same values apply immediately.
//  After rst_n deasserts, the first beat toggle occurs BEAT_DIV clks later.
//  Beat divider: counter runs 0..BEAT_DIV-1; beat toggles on wrap; free-running in all states.
//  FSM states IDLE, WATER, PLAY, KEY; evaluated every clk, priority KEY > PLAY > WATER > IDLE.
//   any state + key_valid -> KEY; latch key_code; load hold counter = HOLD_CYC-1.
//   KEY: hold counter decrements each clk.
//   KEY: a new key_valid re-latches key_code and reloads the counter (restart); takes precedence at expiry.
//   KEY exit: the hold counter is 0 and key_valid=0. Exit target is then chosen as below.
//   Exit/selection without key: play_active -> PLAY; else water enabled -> WATER; else IDLE.
//   PLAY/WATER/IDLE re-select every clk from play_active and func (no hysteresis).
//  led per state (registered, 1-clk latency from sampled inputs):
//   IDLE  : 8'h00
//   WATER : wl_pattern (passed through the register)
//   PLAY  : thermometer of play_note, i.e. (1<<(play_note+1))-1; note 7 -> 8'hFF
//   KEY   : code 0..7 -> one-hot 1<<code; code 8..15 -> ~(1<<(code-8))
//  src equals the state encoding. src and led update on the same edge.
//  func[1:0]==2'b00 or 2'b11 blanks WATER only; KEY and PLAY still display.
//  func[3:2] is ignored.
//  key_valid held high for several clks: each cycle counts as a restart; hold ends HOLD_CYC clks after the last high.
// STRUCTURE
//  Shared package led_ctrl_pkg holds:
//   state/src encodings (IDLE=0, WATER=1, PLAY=2, KEY=3)
//   the one-hot and thermometer decode functions
//  Sub-module beat_divider (params BEAT_DIV, CNT_W; ports clk, rst_n, beat).
//  The top level holds the FSM, the hold counter, the key latch and the LED output register.
// TESTING (bench with BEAT_DIV=4, HOLD_CYC=6)
//  1. Reset release, no requests -> beat toggles every 4 clks; led=00, src=0.
//  2. func=4'b0001, wl_pattern=8'h81 -> next clk src=1, led=81; then func=4'b0011 -> led=00, src=0.
//  3. key_valid pulse with key_code=3 while in WATER -> led=08, src=3 for 6 clks, then led=wl_pattern.
//  4. key_code=2 at t0, key_code=10 at t0+4 -> led=04, then FB from t0+5; KEY held until t0+10 (6 clks after t0+4).
//  5. play_active=1, play_note=4, func=4'b0001 -> led=1F, src=2; drop play_active -> WATER next clk.
//  6. Assert rst_n=0 mid-KEY hold -> led=00, src=0, beat=0 asynchronously; no KEY resumption after release.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: LED bar owner encodings and pattern decode helpers.
package led_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, WATER = 2'd1, PLAY = 2'd2, KEY = 2'd3} state_t;
   // Keys 0..7 light one LED; keys 8..15 light all but one.
   function automatic logic [7:0] key_led(input logic [3:0] code);
      logic [7:0] one;
      one = 8'h01 << code[2:0];
      return code[3] ? ~one : one;
   endfunction
   function automatic logic [7:0] thermo(input logic [2:0] note);
      return ~(8'hFE << note);
   endfunction
endpackage

// File: rtl/beat_divider.sv
// beat_divider: free-running square wave, toggling every BEAT_DIV clocks.
module beat_divider #(
   parameter int BEAT_DIV = 12_500_000,
   parameter int CNT_W    = 25
) (
   input  logic clk,
   input  logic rst_n,
   output logic beat
);
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt  <= '0;
         beat <= 1'b0;
      end else if (cnt == CNT_W'(BEAT_DIV - 1)) begin
         cnt  <= '0;
         beat <= ~beat;
      end else
         cnt <= cnt + 1'b1;
endmodule

// File: rtl/led_bar_scheduler.sv
// led_bar_scheduler: arbitrates the 8-LED bar between key echo, playback and water light.
module led_bar_scheduler
   import led_ctrl_pkg::*;
#(
   parameter int BEAT_DIV = 12_500_000,
   parameter int HOLD_CYC = 25_000_000,
   parameter int CNT_W    = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] func,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       play_active,
   input  logic [2:0] play_note,
   input  logic [7:0] wl_pattern,
   output logic       beat,
   output logic [7:0] led,
   output logic [1:0] src
);
   state_t           state, sel;
   logic [CNT_W-1:0] hold;
   logic [3:0]       key_lat;
   logic             stay, unused;
   assign unused = ^func[3:2];
   assign stay   = (state == KEY) && (hold != '0);
   assign sel    = play_active ? PLAY : (func[1] ^ func[0]) ? WATER : IDLE;
   assign src    = state;
   beat_divider #(.BEAT_DIV(BEAT_DIV), .CNT_W(CNT_W)) u_beat (
      .clk  (clk),
      .rst_n(rst_n),
      .beat (beat)
   );
   // Every key_valid restarts the hold, so a held key keeps the bar until HOLD_CYC after its last cycle.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         hold    <= '0;
         key_lat <= '0;
         led     <= '0;
      end else if (key_valid) begin
         state   <= KEY;
         hold    <= CNT_W'(HOLD_CYC - 1);
         key_lat <= key_code;
         led     <= key_led(key_code);
      end else if (stay) begin
         hold <= hold - 1'b1;
         led  <= key_led(key_lat);
      end else begin
         state <= sel;
         led   <= sel == PLAY ? thermo(play_note) : sel == WATER ? wl_pattern : 8'h00;
      end
endmodule

// File: tb/tb_led_bar_scheduler.sv
// tb_led_bar_scheduler: directed vectors and hand sequences for led_bar_scheduler.
module tb_led_bar_scheduler;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] func = '0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = '0;
   logic       play_active = 1'b0;
   logic [2:0] play_note = '0;
   logic [7:0] wl_pattern = '0;
   logic       beat;
   logic [7:0] led;
   logic [1:0] src;
   int         n_vec = 0;
   int         n_err = 0;

   led_bar_scheduler #(.BEAT_DIV(4), .HOLD_CYC(6), .CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .func       (func),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .play_active(play_active),
      .play_note  (play_note),
      .wl_pattern (wl_pattern),
      .beat       (beat),
      .led        (led),
      .src        (src)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] func;
      logic       kv;
      logic [3:0] code;
      logic       play;
      logic [2:0] note;
      logic [7:0] wl;
      logic [7:0] e_led;
      logic [1:0] e_src;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] f, input logic kv, input logic [3:0] c,
                        input logic p, input logic [2:0] n, input logic [7:0] w);
      func = f; key_valid = kv; key_code = c; play_active = p; play_note = n; wl_pattern = w;
   endtask

   task automatic add(input logic [3:0] f, input logic kv, input logic [3:0] c, input logic p,
                      input logic [2:0] n, input logic [7:0] w, input logic [7:0] el, input logic [1:0] es);
      vec_t v;
      v.func = f; v.kv = kv; v.code = c; v.play = p; v.note = n; v.wl = w; v.e_led = el; v.e_src = es;
      vecs.push_back(v);
   endtask

   initial begin
      // water on/off, key over water with 6-clk hold
      add(4'b0001, 0, 0, 0, 0, 8'h81, 8'h81, 2'd1);
      add(4'b0011, 0, 0, 0, 0, 8'h81, 8'h00, 2'd0);
      add(4'b0010, 0, 0, 0, 0, 8'h3C, 8'h3C, 2'd1);
      add(4'b0010, 1, 3, 0, 0, 8'h3C, 8'h08, 2'd3);
      for (int i = 0; i < 5; i++) add(4'b0010, 0, 0, 0, 0, 8'h3C, 8'h08, 2'd3);
      add(4'b0010, 0, 0, 0, 0, 8'h3C, 8'h3C, 2'd1);
      add(4'b0010, 0, 0, 0, 0, 8'h55, 8'h55, 2'd1);
      // playback thermometer, then back to water
      add(4'b0001, 0, 0, 1, 4, 8'h55, 8'h1F, 2'd2);
      add(4'b0001, 0, 0, 1, 7, 8'h55, 8'hFF, 2'd2);
      add(4'b0001, 0, 0, 1, 0, 8'h55, 8'h01, 2'd2);
      add(4'b0001, 0, 0, 0, 0, 8'h55, 8'h55, 2'd1);
      add(4'b0000, 0, 0, 1, 2, 8'h55, 8'h07, 2'd2);
      add(4'b0000, 0, 0, 0, 0, 8'h55, 8'h00, 2'd0);
      // key held high across three cycles: upper codes and restart
      add(4'b0000, 1, 15, 0, 0, 8'h55, 8'h7F, 2'd3);
      add(4'b0000, 1, 8, 0, 0, 8'h55, 8'hFE, 2'd3);
      add(4'b1100, 1, 0, 0, 0, 8'h55, 8'h01, 2'd3);
      for (int i = 0; i < 5; i++) add(4'b1100, 0, 0, 0, 0, 8'h55, 8'h01, 2'd3);
      add(4'b1100, 0, 0, 0, 0, 8'h55, 8'h00, 2'd0);
      add(4'b1101, 0, 0, 0, 0, 8'hAA, 8'hAA, 2'd1);
      // key expiry with playback pending lands in PLAY
      add(4'b0001, 1, 9, 1, 5, 8'hAA, 8'hFD, 2'd3);
      for (int i = 0; i < 5; i++) add(4'b0001, 0, 0, 1, 5, 8'hAA, 8'hFD, 2'd3);
      add(4'b0001, 0, 0, 1, 5, 8'hAA, 8'h3F, 2'd2);

      #1;
      check("reset_led", led, 8'h00);
      check("reset_src", {6'd0, src}, 8'h00);
      check("reset_beat", {7'd0, beat}, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 1; i <= 9; i++) begin
         tick();
         check($sformatf("beat_%0d", i), {7'd0, beat}, {7'd0, 1'((i / 4) % 2)});
         check($sformatf("idle_led_%0d", i), led, 8'h00);
      end

      foreach (vecs[i]) begin
         drive(vecs[i].func, vecs[i].kv, vecs[i].code, vecs[i].play, vecs[i].note, vecs[i].wl);
         tick();
         check($sformatf("vec%0d_led", i), led, vecs[i].e_led);
         check($sformatf("vec%0d_src", i), {6'd0, src}, {6'd0, vecs[i].e_src});
      end

      // key 2 then key 10 four clocks later: hold restarts from the second key
      drive(4'b0000, 0, 0, 0, 0, 8'h00);
      tick();
      check("seq4_idle", led, 8'h00);
      for (int t = 0; t < 11; t++) begin
         drive(4'b0000, t == 0 || t == 4, t == 0 ? 4'd2 : 4'd10, 0, 0, 8'h00);
         tick();
         check($sformatf("seq4_led_t%0d", t), led, t < 4 ? 8'h04 : t < 10 ? 8'hFB : 8'h00);
         check($sformatf("seq4_src_t%0d", t), {6'd0, src}, t < 10 ? 8'd3 : 8'd0);
      end

      // asynchronous reset in the middle of a key hold
      drive(4'b0000, 1, 5, 0, 0, 8'h00);
      tick();
      check("seq6_key_led", led, 8'h20);
      drive(4'b0000, 0, 0, 0, 0, 8'h00);
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("seq6_async_led", led, 8'h00);
      check("seq6_async_src", {6'd0, src}, 8'h00);
      check("seq6_async_beat", {7'd0, beat}, 8'h00);
      @(negedge clk) rst_n = 1'b1;
      for (int t = 0; t < 4; t++) begin
         tick();
         check($sformatf("seq6_post_led_%0d", t), led, 8'h00);
         check($sformatf("seq6_post_src_%0d", t), {6'd0, src}, 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
endmodule
